// File: rtl/sync_pkg.sv
// Shared definitions for the sync normalizer: lock-FSM state encoding, the
// default counter width and a saturating increment helper.
package sync_pkg;

  localparam int CNT_W_DEF = 20;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  typedef enum logic [1:0] {
    UNLOCKED = ST_UNLOCKED,
    ACQUIRE  = ST_ACQUIRE,
    LOCKED   = ST_LOCKED,
    HOLD     = ST_HOLD
  } lock_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_normalizer_if.sv
// Signal bundle between the sync polarity detector side and the timing
// generator side of the sync normalizer.
interface sync_normalizer_if #(
  parameter int CNT_W = 20
);
  logic             sync_in;
  logic             positive_polarity_in;
  logic             sync_out;
  logic             sync_start_out;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] width_out;
  logic             locked_out;

  modport master (
    output sync_in, positive_polarity_in,
    input  sync_out, sync_start_out, period_out, width_out, locked_out
  );

  modport slave (
    input  sync_in, positive_polarity_in,
    output sync_out, sync_start_out, period_out, width_out, locked_out
  );
endinterface

// File: rtl/sync_glitch_filter.sv
// Level filter: the output follows the input only after the input has held a
// new level for GLITCH_CYC consecutive cycles; shorter excursions are dropped.
module sync_glitch_filter #(
  parameter int GLITCH_CYC = 3
) (
  input  logic clk_50mhz_in,
  input  logic reset,
  input  logic level_in,
  output logic level_out
);
  localparam int CW = $clog2(GLITCH_CYC + 1);

  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      level_out  <= 1'b0;
      stable_cnt <= '0;
    end else if (level_in == level_out) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(GLITCH_CYC - 1)) begin
      level_out  <= level_in;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sync_normalizer.sv
// Sync normalizer: polarity-corrects raw sync, measures period/width and runs
// the lock FSM. Optional input glitch filter: SYNC_NORMALIZER_GLITCH_FILTER_EN.
module sync_normalizer
  import sync_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TOL        = 8,
  parameter int LOCK_COUNT = 16,
`ifdef SYNC_NORMALIZER_GLITCH_FILTER_EN
  parameter int GLITCH_CYC = 3,
`endif
  parameter int MISS_LIMIT = 4
) (
  input logic              clk_50mhz_in,
  input logic              reset,
  sync_normalizer_if.slave bus
);
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(MISS_LIMIT + 1);

  logic sync_p0, sync_p1, pol_p1;
  logic n_raw, acc, pol_chg;
  logic sync_q, start_q, armed_q, have_edge_q, locked_q;
  logic lead, trail, timeout, new_per, match;
  logic [CNT_W-1:0] pcnt_q, wcnt_q, pcnt_inc, wcnt_inc;
  logic [CNT_W-1:0] period_q, width_q, ref_q, ref_d;
  logic [CNT_W:0]   diff, abs_diff;
  lock_state_e      st_q, st_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic [MS_W-1:0]  ms_q, ms_d;

  // Stage p0/p1: two-flop synchronizer for the asynchronous sync input
  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      pol_p1  <= 1'b0;
    end else begin
      sync_p0 <= bus.sync_in;
      sync_p1 <= sync_p0;
      pol_p1  <= bus.positive_polarity_in;
    end
  end

  assign n_raw   = sync_p1 ^ ~bus.positive_polarity_in;
  assign pol_chg = bus.positive_polarity_in ^ pol_p1;

`ifdef SYNC_NORMALIZER_GLITCH_FILTER_EN
  sync_glitch_filter #(.GLITCH_CYC(GLITCH_CYC)) u_glitch_filter (
    .clk_50mhz_in (clk_50mhz_in),
    .reset        (reset),
    .level_in     (n_raw),
    .level_out    (acc)
  );
`else
  assign acc = n_raw;
`endif

  assign lead     = ~pol_chg & armed_q & acc & ~sync_q;
  assign trail    = ~pol_chg & armed_q & ~acc & sync_q;
  assign timeout  = ~pol_chg & ~lead & (pcnt_q == CNT_MAX[CNT_W-1:0]);
  assign new_per  = lead & have_edge_q;
  assign pcnt_inc = CNT_W'(sat_inc(32'(pcnt_q), CNT_MAX));
  assign wcnt_inc = CNT_W'(sat_inc(32'(wcnt_q), CNT_MAX));
  assign diff     = {1'b0, pcnt_inc} - {1'b0, ref_q};
  assign abs_diff = diff[CNT_W] ? (~diff + (CNT_W+1)'(1)) : diff;
  assign match    = abs_diff <= (CNT_W+1)'(TOL);

  // Stage p2: accepted level, edge strobes and period/width measurement.
  // After a polarity flip nothing is accepted until the level reads idle,
  // so the inverted level never produces a leading edge of its own.
  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      sync_q      <= 1'b0;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      have_edge_q <= 1'b0;
      pcnt_q      <= '0;
      wcnt_q      <= '0;
      period_q    <= '0;
      width_q     <= '0;
    end else if (pol_chg) begin
      sync_q      <= 1'b0;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      have_edge_q <= 1'b0;
      pcnt_q      <= '0;
      wcnt_q      <= '0;
    end else begin
      if (!armed_q && !acc && !n_raw) armed_q <= 1'b1;
      sync_q  <= armed_q & acc;
      start_q <= lead;
      if (lead) begin
        pcnt_q      <= '0;
        wcnt_q      <= '0;
        have_edge_q <= 1'b1;
        if (have_edge_q) period_q <= pcnt_inc;
      end else begin
        pcnt_q <= pcnt_inc;
        if (timeout) have_edge_q <= 1'b0;
        if (armed_q && acc) wcnt_q <= wcnt_inc;
      end
      if (trail) width_q <= wcnt_inc;
    end
  end

  // Lock FSM. The reference period only follows periods that were trusted, so
  // a run of identical off-frequency lines keeps counting as misses in HOLD.
  always_comb begin
    st_d  = st_q;
    mc_d  = mc_q;
    ms_d  = ms_q;
    ref_d = ref_q;
    if (pol_chg || timeout) begin
      st_d = UNLOCKED;
    end else if (new_per) begin
      case (st_q)
        UNLOCKED: begin
          st_d  = ACQUIRE;
          mc_d  = '0;
          ref_d = pcnt_inc;
        end
        ACQUIRE: begin
          ref_d = pcnt_inc;
          if (!match)                                  mc_d = '0;
          else if (mc_q + MC_W'(1) == MC_W'(LOCK_COUNT - 1)) st_d = LOCKED;
          else                                         mc_d = mc_q + MC_W'(1);
        end
        LOCKED: begin
          if (match) begin
            ref_d = pcnt_inc;
          end else begin
            st_d = HOLD;
            ms_d = MS_W'(1);
          end
        end
        HOLD: begin
          if (match) begin
            st_d  = LOCKED;
            ms_d  = '0;
            ref_d = pcnt_inc;
          end else if (ms_q == MS_W'(MISS_LIMIT - 1)) begin
            st_d = UNLOCKED;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      st_q     <= UNLOCKED;
      mc_q     <= '0;
      ms_q     <= '0;
      ref_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      mc_q     <= mc_d;
      ms_q     <= ms_d;
      ref_q    <= ref_d;
      locked_q <= (st_d == LOCKED) || (st_d == HOLD);
    end
  end

  assign bus.sync_out       = sync_q;
  assign bus.sync_start_out = start_q;
  assign bus.period_out     = period_q;
  assign bus.width_out      = width_q;
  assign bus.locked_out     = locked_q;

endmodule
